// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline constants and the fetch state encoding.
// Imported by the fetch unit and reused by the IF/ID flush value.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the imem req/ack
// handshake and presents {PC+4, Instruction} or a NOP bubble to IF/ID.
// Ports: clk, rst (async, active high), freeze, branch_taken,
//   branch_addr, imem_req/imem_addr/imem_ack/imem_rdata, PC,
//   Instruction; bubble_cnt only when IF_BUBBLE_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = if_fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction
`ifdef IF_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  import if_fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  pend_q, pend_d;
  logic         req;
  logic         done;
  logic         unused_addr_lsb;

  assign unused_addr_lsb = ^branch_addr[1:0];

  always_comb begin
    req       = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      FETCH:   req = 1'b1;
      HOLD:    req = !freeze;
      FLUSH: begin
        req       = 1'b1;
        imem_addr = pend_q;
      end
      default: req = 1'b0;
    endcase
  end

  assign imem_req = req && !rst;
  assign done     = imem_req && imem_ack;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    valid_d     = valid_q;
    pend_d      = pend_q;
    unique case (state_q)
      FETCH: begin
        if (done) begin
          buf_instr_d = imem_rdata;
          buf_pc_d    = pc_q;
          pc_d        = pc_q + 32'd4;
          valid_d     = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (!freeze) begin
          if (done) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
          end else begin
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
      end
      FLUSH: begin
        if (done) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Redirect wins over everything; an unacked request must still
    // complete at its old address, so park it in FLUSH.
    if (branch_taken) begin
      pc_d    = {branch_addr[31:2], 2'b00};
      valid_d = 1'b0;
      if (imem_req && !imem_ack) begin
        if (state_q != FLUSH) pend_d = imem_addr;
        state_d = FLUSH;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      valid_q     <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      valid_q     <= valid_d;
      pend_q      <= pend_d;
    end
  end

  assign Instruction = valid_q ? buf_instr_q : NOP_INSTR;
  assign PC          = valid_q ? buf_pc_q + 32'd4 : 32'd0;

`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (!freeze && !valid_q && bubble_q != 32'hFFFF_FFFF)
      bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_q <= '0;
    else     bubble_q <= bubble_d;
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle tables plus hand sequences
// for ack latency, branch flush and reset during a flush.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [1:0] lat_sel = 2'd0;
  logic [1:0] wait_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Memory model: ack on the (lat_sel+1)-th cycle of a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= '0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 2'd1;
    else wait_cnt <= '0;
  end

  assign imem_ack   = imem_req && (wait_cnt >= lat_sel);
  assign imem_rdata = mem_word(imem_addr);

  if_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .PC(PC),
    .Instruction(Instruction)
`ifdef IF_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    logic        fz;
    logic        br;
    logic [31:0] ba;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, advance.
  task automatic step(input string nm, input logic fz, input logic br,
                      input logic [31:0] ba, input logic req,
                      input logic [31:0] addr, input logic [31:0] pc);
    logic [31:0] ei;
    freeze       = fz;
    branch_taken = br;
    branch_addr  = ba;
    #1;
    ei = (pc == 32'd0) ? NOP : mem_word(pc - 32'd4);
    chk({nm, " req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({nm, " addr"}, imem_addr, addr);
    chk({nm, " pc"}, PC, pc);
    chk({nm, " instr"}, Instruction, ei);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] lat);
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    lat_sel      = lat;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req", {31'd0, imem_req}, 32'd0);
    chk("rst pc", PC, 32'd0);
    chk("rst instr", Instruction, NOP);
`ifdef IF_BUBBLE_CNT_EN
    chk("rst bubble", bubble_cnt, 32'd0);
`endif
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h0};
    tv[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h4};
    tv[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h8};
    tv[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'hC};
    tv[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'hC};
    tv[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'hC};
    tv[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'hC};
    tv[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   32'hC};
    tv[8]  = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h10,  32'h10};
    tv[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h0};
    tv[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 32'h104};
    tv[11] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h108};
    tv[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 32'h0};
    tv[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 32'h204};

    // Zero-wait stream, freeze window, branches.
    @(negedge clk);
    do_reset(2'd0);
    for (int i = 0; i < 14; i++)
      step($sformatf("zw%0d", i), tv[i].fz, tv[i].br, tv[i].ba,
           tv[i].req, tv[i].addr, tv[i].pc);

    // Three-cycle ack latency, then a branch while 8 is unacked.
    do_reset(2'd2);
    step("l3c0", 0, 0, 0, 1, 32'h0, 32'h0);
    step("l3c1", 0, 0, 0, 1, 32'h0, 32'h0);
    step("l3c2", 0, 0, 0, 1, 32'h0, 32'h0);
    step("l3c3", 0, 0, 0, 1, 32'h4, 32'h4);
    step("l3c4", 0, 0, 0, 1, 32'h4, 32'h0);
    step("l3c5", 0, 0, 0, 1, 32'h4, 32'h0);
`ifdef IF_BUBBLE_CNT_EN
    #1 chk("bubble l3c6", bubble_cnt, 32'd5);
`endif
    step("l3c6", 0, 0, 0, 1, 32'h8, 32'h8);
    step("l3c7", 0, 1, 32'h103, 1, 32'h8, 32'h0);
    step("l3c8", 0, 0, 0, 1, 32'h8, 32'h0);
    step("l3c9", 0, 0, 0, 1, 32'h100, 32'h0);
    step("l3c10", 0, 0, 0, 1, 32'h100, 32'h0);
    step("l3c11", 0, 0, 0, 1, 32'h100, 32'h0);
`ifdef IF_BUBBLE_CNT_EN
    #1 chk("bubble l3c12", bubble_cnt, 32'd10);
`endif
    step("l3c12", 0, 0, 0, 1, 32'h104, 32'h104);

    // Branch with freeze and a same-cycle ack in FETCH.
    do_reset(2'd0);
    step("bfz0", 1, 1, 32'h300, 1, 32'h0, 32'h0);
    step("bfz1", 0, 0, 0, 1, 32'h300, 32'h0);
    step("bfz2", 0, 0, 0, 1, 32'h304, 32'h304);

    // Reset while waiting in FLUSH.
    do_reset(2'd2);
    step("rf0", 0, 0, 0, 1, 32'h0, 32'h0);
    step("rf1", 0, 1, 32'h40, 1, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rf rst req", {31'd0, imem_req}, 32'd0);
    chk("rf rst pc", PC, 32'd0);
    chk("rf rst instr", Instruction, NOP);
`ifdef IF_BUBBLE_CNT_EN
    chk("rf rst bubble", bubble_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step("rf2", 0, 0, 0, 1, 32'h0, 32'h0);
    step("rf3", 0, 0, 0, 1, 32'h0, 32'h0);
    step("rf4", 0, 0, 0, 1, 32'h0, 32'h0);
    step("rf5", 0, 0, 0, 1, 32'h4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage ARM-style pipeline.
- Owns the program counter and issues requests to the instruction memory over a req/ack handshake.
- Presents {PC+4, Instruction} to the IF/ID pipeline register each cycle, or a NOP bubble while no instruction is ready.
- Obeys the hazard-unit freeze; redirects on a branch taken from EXE.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'hE000_0000, bubble word: condition AL, all other fields zero.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall; IF/ID register holds this cycle.
- branch_taken  in  1  one-cycle redirect pulse from EXE.
- branch_addr  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory completes the request this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- PC  out  32  fetched address + 4; 0 when bubbling.
- Instruction  out  32  fetched word; NOP_INSTR when bubbling.

Behaviour:
- Registered state: state, pc_reg, buf_instr, buf_pc, valid, pend_addr.
- Handshake rule: once imem_req=1 without imem_ack, imem_req and imem_addr stay stable until the ack. A transaction completes only in a cycle where imem_req=1 and imem_ack=1.
- Outputs: Instruction = valid ? buf_instr : NOP_INSTR. PC = valid ? buf_pc+4 : 0 (32-bit, wraps).
- Reset (async): state=FETCH, pc_reg=RESET_PC, valid=0, buffers=0. imem_req is forced 0 while rst=1. First request is issued in the first cycle after rst falls.
- FETCH: imem_req=1, imem_addr=pc_reg.
  - On ack: buf_instr<=imem_rdata, buf_pc<=pc_reg, pc_reg<=pc_reg+4, valid<=1, go to HOLD.
  - No ack: stay in FETCH.
- HOLD: the instruction is presented.
  - freeze=1: imem_req=0; hold everything.
  - freeze=0: handoff occurs this cycle; imem_req=1, imem_addr=pc_reg.
    - With ack: refill the buffer as in FETCH and stay in HOLD. This gives 1 instruction/cycle with a zero-wait memory.
    - Without ack: valid<=0, go to FETCH.
- FLUSH: imem_req=1, imem_addr=pend_addr. On ack: discard the data, go to FETCH. pc_reg already holds the branch target.
- Branch (branch_taken=1): highest priority, applies regardless of freeze or state.
  - pc_reg<={branch_addr[31:2],2'b00}, valid<=0.
  - If imem_req=1 and imem_ack=0 this cycle: pend_addr<=imem_addr, go to FLUSH. In FLUSH itself, pend_addr is unchanged.
  - Otherwise go to FETCH; any same-cycle ack data is dropped.
- Back-to-back branches in FLUSH update only pc_reg.
- Latency: in a zero-wait system, a branch in cycle N means the target instruction is presented at N+2.
- freeze never blocks a request already outstanding in FETCH or FLUSH.

Optional Feature:
- Macro IF_BUBBLE_CNT_EN.
- Defined: adds output bubble_cnt [31:0]. It resets to 0 and increments (saturating at 32'hFFFF_FFFF) each cycle with freeze=0 and valid=0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR and RESET_PC constants, reused by the IF/ID register flush value.
  - Fetch state enum {FETCH, HOLD, FLUSH}, 2-bit.
- Single module; no sub-module warranted. The optional counter stays inline.

Test Plan:
- Zero-wait memory (ack=req), no freeze, from reset → addresses 0,4,8,… one per cycle; Instruction=mem[k], PC=4(k+1); first valid output 1 cycle after the first request.
- 3-cycle ack latency → imem_addr stable through the wait; NOP_INSTR/PC=0 on the two bubble cycles per fetch.
- freeze held 4 cycles while in HOLD with Instruction=mem[2] → imem_req=0 throughout, outputs frozen; fetch of 12 follows the release.
- branch_taken with branch_addr=32'h103 while a request to 8 is unacked (latency 3) → req stays at 8 until ack, that data is dropped, next request goes to 32'h100, and its instruction is presented with PC=32'h104.
- branch_taken coinciding with freeze=1 and a same-cycle ack → ack data dropped, next request goes to the branch target.
- rst asserted mid-wait in FLUSH → imem_req=0 immediately, outputs NOP_INSTR/0; after release the fetch restarts at RESET_PC. With IF_BUBBLE_CNT_EN, bubble_cnt=0 after reset and equals the bubble count in the latency-3 scenario.
